// File: rtl/pal_cfg_pkg.sv
// Shared types and constants for the PAL configuration loader.
package pal_cfg_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CRC     = 2'd2
    } pal_cfg_state_t;

    localparam logic [7:0] CRC_POLY     = 8'h07;
    localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

    // Two N*P planes plus the P*M output section of the PAL fabric.
    function automatic int pal_cfg_bits(input int n, input int m, input int p);
        return 2 * n * p + p * m;
    endfunction

endpackage

// File: rtl/pal_crc8_ser.sv
// Bit-serial CRC-8 (poly 0x07, init 0x00), MSB first.
module pal_crc8_ser
    import pal_cfg_pkg::*;
(
    input  logic       clk,
    input  logic       res_n,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [7:0] crc
);

    logic fb;

    assign fb = crc[7] ^ din;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            crc <= 8'h00;
        end else if (clr) begin
            crc <= 8'h00;
        end else if (en) begin
            crc <= {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
        end
    end

endmodule

// File: rtl/pal_cfg_loader.sv
// Serial config front-end: sync hunt, fixed-length payload shift into the PAL
// chain, trailing CRC-8 check with held ok/err status and an idle timeout.
module pal_cfg_loader
    import pal_cfg_pkg::*;
#(
    parameter int         CFG_BITS = pal_cfg_bits(8, 4, 14),
    parameter logic [7:0] SYNC     = DEFAULT_SYNC,
    parameter int         TIMEOUT  = 1023
) (
    input  logic clk,
    input  logic res_n,
    input  logic ser_in,
    input  logic ser_valid,
    output logic pal_cfg,
    output logic pal_en,
    output logic busy,
    output logic cfg_ok,
    output logic cfg_err
);

    localparam int BIT_W  = $clog2(CFG_BITS);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(CFG_BITS - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    pal_cfg_state_t    state;
    logic [7:0]        sync_sr;
    logic [BIT_W-1:0]  bit_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [2:0]        crc_cnt;
    logic [7:0]        crc_rx;
    logic [7:0]        crc_val;
    logic [7:0]        sync_next;
    logic [7:0]        crc_rx_next;
    logic              sync_hit;
    logic              crc_en;
    logic              timeout_hit;

    assign sync_next   = {sync_sr[6:0], ser_in};
    assign crc_rx_next = {crc_rx[6:0], ser_in};
    assign sync_hit    = (state == HUNT) && ser_valid && (sync_next == SYNC);
    assign crc_en      = (state == PAYLOAD) && ser_valid;
    // A strobe in the expiry cycle wins, so the timeout only fires when idle.
    assign timeout_hit = (state != HUNT) && !ser_valid && (idle_cnt == IDLE_LAST);

    pal_crc8_ser u_crc (
        .clk   (clk),
        .res_n (res_n),
        .clr   (sync_hit),
        .en    (crc_en),
        .din   (ser_in),
        .crc   (crc_val)
    );

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state    <= HUNT;
            sync_sr  <= 8'h00;
            bit_cnt  <= '0;
            idle_cnt <= '0;
            crc_cnt  <= 3'd0;
            crc_rx   <= 8'h00;
            pal_cfg  <= 1'b0;
            pal_en   <= 1'b0;
            busy     <= 1'b0;
            cfg_ok   <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            pal_en <= 1'b0;
            case (state)
                HUNT: begin
                    if (sync_hit) begin
                        // Clearing the shifter stops overlapping sync patterns re-firing.
                        sync_sr  <= 8'h00;
                        bit_cnt  <= '0;
                        idle_cnt <= '0;
                        crc_cnt  <= 3'd0;
                        cfg_ok   <= 1'b0;
                        cfg_err  <= 1'b0;
                        busy     <= 1'b1;
                        state    <= PAYLOAD;
                    end else if (ser_valid) begin
                        sync_sr <= sync_next;
                    end
                end
                PAYLOAD: begin
                    if (ser_valid) begin
                        pal_cfg  <= ser_in;
                        pal_en   <= 1'b1;
                        idle_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            state <= CRC;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (timeout_hit) begin
                        idle_cnt <= '0;
                        cfg_err  <= 1'b1;
                        busy     <= 1'b0;
                        state    <= HUNT;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                CRC: begin
                    if (ser_valid) begin
                        crc_rx   <= crc_rx_next;
                        idle_cnt <= '0;
                        if (crc_cnt == 3'd7) begin
                            cfg_ok  <= (crc_rx_next == crc_val);
                            cfg_err <= (crc_rx_next != crc_val);
                            busy    <= 1'b0;
                            state   <= HUNT;
                        end else begin
                            crc_cnt <= crc_cnt + 1'b1;
                        end
                    end else if (timeout_hit) begin
                        idle_cnt <= '0;
                        cfg_err  <= 1'b1;
                        busy     <= 1'b0;
                        state    <= HUNT;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= HUNT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Scoreboard bench for pal_cfg_loader with a short 16-bit frame and 15-cycle timeout.
module tb_pal_cfg_loader;

    typedef struct packed {
        logic       is_status;
        logic [1:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic res_n;
    logic ser_in;
    logic ser_valid;
    logic pal_cfg;
    logic pal_en;
    logic busy;
    logic cfg_ok;
    logic cfg_err;

    int   n_vec  = 0;
    int   n_fail = 0;
    logic prev_busy = 1'b0;
    exp_t exp_q[$];

    pal_cfg_loader #(
        .CFG_BITS (16),
        .SYNC     (8'hA5),
        .TIMEOUT  (15)
    ) dut (
        .clk       (clk),
        .res_n     (res_n),
        .ser_in    (ser_in),
        .ser_valid (ser_valid),
        .pal_cfg   (pal_cfg),
        .pal_en    (pal_en),
        .busy      (busy),
        .cfg_ok    (cfg_ok),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic popCheck(input logic kind, input logic [1:0] act, input string name);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("[TB] FAIL %s: unexpected output %b with nothing expected at %0t", name, act, $time);
        end else begin
            e = exp_q.pop_front();
            checkOutput(name, {5'd0, kind, act}, {5'd0, e.is_status, e.val});
        end
    endtask

    // Monitor: every pal_en pulse and every frame end (busy falling) consumes one expectation.
    always @(negedge clk) begin
        if (!res_n) begin
            prev_busy = 1'b0;
        end else begin
            if (pal_en) popCheck(1'b0, {1'b0, pal_cfg}, "pal_cfg");
            if (prev_busy && !busy) popCheck(1'b1, {cfg_ok, cfg_err}, "status");
            prev_busy = busy;
        end
    end

    task automatic applyStimulus(input logic b);
        ser_in    = b;
        ser_valid = 1'b1;
        @(negedge clk);
        ser_valid = 1'b0;
        ser_in    = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sendByte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) applyStimulus(v[i]);
    endtask

    task automatic sendFrame(input logic [15:0] payload, input logic [7:0] crc,
                             input logic ok, input int gap);
        sendByte(8'hA5);
        for (int i = 15; i >= 0; i--) begin
            exp_q.push_back({1'b0, 1'b0, payload[i]});
            applyStimulus(payload[i]);
            if (gap > 0 && i == 15) idleCycles(gap);
            if (gap > 0 && i == 14) begin
                checkOutput("late_strobe_busy", {7'd0, busy}, 8'd1);
                checkOutput("late_strobe_err", {7'd0, cfg_err}, 8'd0);
            end
        end
        exp_q.push_back({1'b1, ok, ~ok});
        sendByte(crc);
    endtask

    initial begin
        res_n     = 1'b0;
        ser_in    = 1'b0;
        ser_valid = 1'b0;
        idleCycles(3);
        checkOutput("rst_pal_cfg", {7'd0, pal_cfg}, 8'd0);
        checkOutput("rst_pal_en", {7'd0, pal_en}, 8'd0);
        checkOutput("rst_busy", {7'd0, busy}, 8'd0);
        checkOutput("rst_cfg_ok", {7'd0, cfg_ok}, 8'd0);
        checkOutput("rst_cfg_err", {7'd0, cfg_err}, 8'd0);
        res_n = 1'b1;
        idleCycles(2);

        // All-zero payload, CRC 0x00.
        sendFrame(16'h0000, 8'h00, 1'b1, 0);
        idleCycles(3);
        checkOutput("f1_busy", {7'd0, busy}, 8'd0);
        checkOutput("f1_ok", {7'd0, cfg_ok}, 8'd1);

        // Single trailing one gives CRC 0x07; then the same payload with a bad CRC.
        sendFrame(16'h0001, 8'h07, 1'b1, 0);
        idleCycles(2);
        sendFrame(16'h0001, 8'h06, 1'b0, 0);
        idleCycles(3);
        checkOutput("f3_err", {7'd0, cfg_err}, 8'd1);
        checkOutput("f3_ok", {7'd0, cfg_ok}, 8'd0);

        // Garbage without any embedded A5 window, then a frame whose CRC is 0xB6.
        sendByte(8'hFF);
        sendByte(8'h3C);
        sendFrame(16'h8000, 8'hB6, 1'b1, 0);
        idleCycles(4);
        checkOutput("f4_ok_held", {7'd0, cfg_ok}, 8'd1);

        // A new sync clears the held status at once; then starve it into a timeout.
        sendByte(8'hA5);
        checkOutput("resync_ok_cleared", {7'd0, cfg_ok}, 8'd0);
        checkOutput("resync_busy", {7'd0, busy}, 8'd1);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({1'b0, 1'b0, 1'(i % 2)});
            applyStimulus(1'(i % 2));
        end
        exp_q.push_back({1'b1, 1'b0, 1'b1});
        idleCycles(15);
        checkOutput("timeout_busy", {7'd0, busy}, 8'd0);
        checkOutput("timeout_err", {7'd0, cfg_err}, 8'd1);
        idleCycles(2);

        // Strobe exactly in the expiry cycle keeps the frame alive.
        sendFrame(16'h0000, 8'h00, 1'b1, 14);
        idleCycles(3);
        checkOutput("late_frame_ok", {7'd0, cfg_ok}, 8'd1);

        // Asynchronous reset after the 8th payload bit.
        sendByte(8'hA5);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({1'b0, 1'b0, 1'b1});
            applyStimulus(1'b1);
        end
        #2 res_n = 1'b0;
        #1;
        checkOutput("midrst_pal_cfg", {7'd0, pal_cfg}, 8'd0);
        checkOutput("midrst_pal_en", {7'd0, pal_en}, 8'd0);
        checkOutput("midrst_busy", {7'd0, busy}, 8'd0);
        checkOutput("midrst_cfg_ok", {7'd0, cfg_ok}, 8'd0);
        checkOutput("midrst_cfg_err", {7'd0, cfg_err}, 8'd0);
        idleCycles(2);
        res_n = 1'b1;
        idleCycles(2);
        sendFrame(16'h0001, 8'h07, 1'b1, 0);
        idleCycles(5);
        checkOutput("post_rst_ok", {7'd0, cfg_ok}, 8'd1);
        checkOutput("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
